// File: rtl/mio_arbiter_if.sv
// mio_arbiter_if: CPU, debug/DMA and memory-port signal bundle around mio_arbiter
// Ports: slave modport is the arbiter side (takes requests and mem_rdata, returns
//   rdata/ready/ack and drives the memory port); master modport is the SoC side.
interface mio_arbiter_if;
   logic        cpu_req;
   logic        cpu_we;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        cpu_ready;
   logic        dbg_req;
   logic        dbg_we;
   logic [31:0] dbg_addr;
   logic [31:0] dbg_wdata;
   logic [31:0] dbg_rdata;
   logic        dbg_ack;
   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, dbg_req, dbg_we, dbg_addr, dbg_wdata, mem_rdata,
      output cpu_rdata, cpu_ready, dbg_rdata, dbg_ack, mem_en, mem_we, mem_addr, mem_wdata
   );
   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, dbg_req, dbg_we, dbg_addr, dbg_wdata, mem_rdata,
      input  cpu_rdata, cpu_ready, dbg_rdata, dbg_ack, mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mio_arbiter.sv
// mio_arbiter: shares one fixed-latency data-memory port between the CPU and the debug/DMA port
// Ports: clk; rst (synchronous, active-high); bus (mio_arbiter_if.slave) with the CPU
//   request/response, debug request/response and memory-port signals.
// MEM_LAT (1..15): cycles from the first mem_en cycle to valid mem_rdata.
// RR_PRIORITY_EN: when defined, ties go to the requester not granted last;
//   otherwise the CPU always wins ties.
module mio_arbiter #(
   parameter int MEM_LAT = 1
) (
   input logic          clk,
   input logic          rst,
   mio_arbiter_if.slave bus
);
   localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2;
   localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);
   logic [1:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        gnt_q, gnt_d, last_q, last_d, we_q, we_d, win;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
   logic [31:0] cpu_rdata_q, cpu_rdata_d, dbg_rdata_q, dbg_rdata_d;
`ifdef RR_PRIORITY_EN
   assign win = bus.dbg_req & (~bus.cpu_req | ~last_q);
`else
   assign win = ~bus.cpu_req;
`endif
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      gnt_d       = gnt_q;
      last_d      = last_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      cpu_rdata_d = cpu_rdata_q;
      dbg_rdata_d = dbg_rdata_q;
      if (state_q == IDLE && (bus.cpu_req || bus.dbg_req)) begin
         gnt_d   = win;
         we_d    = win ? bus.dbg_we : bus.cpu_we;
         addr_d  = win ? bus.dbg_addr : bus.cpu_addr;
         wdata_d = win ? bus.dbg_wdata : bus.cpu_wdata;
         cnt_d   = CNT_INIT;
         state_d = ACCESS;
      end else if (state_q == ACCESS) begin
         if (cnt_q == 4'd0) begin
            cpu_rdata_d = gnt_q ? cpu_rdata_q : bus.mem_rdata;
            dbg_rdata_d = gnt_q ? bus.mem_rdata : dbg_rdata_q;
            state_d     = RESP;
         end else begin
            cnt_d = cnt_q - 4'd1;
         end
      end else if (state_q == RESP) begin
         last_d  = gnt_q;
         state_d = IDLE;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         gnt_q       <= 1'b0;
         last_q      <= 1'b1;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         cpu_rdata_q <= '0;
         dbg_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         gnt_q       <= gnt_d;
         last_q      <= last_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         cpu_rdata_q <= cpu_rdata_d;
         dbg_rdata_q <= dbg_rdata_d;
      end
   end
   // The counter still holds its load value only in the first ACCESS cycle,
   // so gating on it yields exactly one write strobe.
   assign bus.mem_en    = state_q == ACCESS;
   assign bus.mem_we    = state_q == ACCESS && we_q && cnt_q == CNT_INIT;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.cpu_rdata = cpu_rdata_q;
   assign bus.dbg_rdata = dbg_rdata_q;
   assign bus.cpu_ready = state_q == RESP && !gnt_q;
   assign bus.dbg_ack   = state_q == RESP && gnt_q;
endmodule

// File: tb/tb_mio_arbiter.sv
// tb_mio_arbiter: directed vector table plus corner-case sequences for mio_arbiter
module tb_mio_arbiter;
   typedef struct {
      logic        rst, creq, cwe, dreq, dwe;
      logic [31:0] caddr, cwd, daddr, dwd, mrd;
      logic        en, we, crdy, dack, chk_c, chk_d;
      logic [31:0] addr, wd, crd, drd;
   } vec_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int vecs = 0;
   int miss = 0;
   vec_t tbl[$];
   logic [31:0] ec, ed;
   logic cc, cd;
   mio_arbiter_if bus2 ();
   mio_arbiter_if bus1 ();
   mio_arbiter #(.MEM_LAT(2)) u2 (.clk(clk), .rst(rst), .bus(bus2));
   mio_arbiter #(.MEM_LAT(1)) u1 (.clk(clk), .rst(rst), .bus(bus1));
   always #5 clk = ~clk;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         miss++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   task automatic chk1(input string nm, input logic act, input logic exp);
      chk(nm, {31'b0, act}, {31'b0, exp});
   endtask
   // ib = {rst, cpu_req, cpu_we, dbg_req, dbg_we}; ob = {mem_en, mem_we, cpu_ready, dbg_ack}
   task automatic add(input logic [4:0] ib, input logic [31:0] caddr, input logic [31:0] cwd,
                      input logic [31:0] daddr, input logic [31:0] dwd, input logic [31:0] mrd,
                      input logic [3:0] ob, input logic [31:0] addr, input logic [31:0] wd);
      vec_t v;
      {v.rst, v.creq, v.cwe, v.dreq, v.dwe} = ib;
      {v.en, v.we, v.crdy, v.dack} = ob;
      v.caddr = caddr; v.cwd = cwd; v.daddr = daddr; v.dwd = dwd; v.mrd = mrd;
      v.addr = addr; v.wd = wd;
      v.chk_c = cc; v.chk_d = cd; v.crd = ec; v.drd = ed;
      tbl.push_back(v);
   endtask
   task automatic idle_inputs();
      {bus2.cpu_req, bus2.cpu_we, bus2.dbg_req, bus2.dbg_we} = '0;
      {bus2.cpu_addr, bus2.cpu_wdata, bus2.dbg_addr, bus2.dbg_wdata, bus2.mem_rdata} = '0;
      {bus1.cpu_req, bus1.cpu_we, bus1.dbg_req, bus1.dbg_we} = '0;
      {bus1.cpu_addr, bus1.cpu_wdata, bus1.dbg_addr, bus1.dbg_wdata, bus1.mem_rdata} = '0;
   endtask
   initial begin
      logic w;
      logic [31:0] v, a, rd;
      int pulses, at, acks, ens;
      idle_inputs();
      ec = '0; ed = '0; cc = 1'b1; cd = 1'b1;
      add(5'b11000, 32'h100, 0, 0, 0, 32'hDEADBEEF, 4'b0000, 0, 0);
      add(5'b11000, 32'h100, 0, 0, 0, 32'hDEADBEEF, 4'b0000, 0, 0);
      add(5'b01000, 32'h100, 0, 0, 0, 32'hDEADBEEF, 4'b0000, 0, 0);
      add(5'b01000, 32'h100, 0, 0, 0, 32'hDEADBEEF, 4'b1000, 32'h100, 0);
      add(5'b01000, 32'h100, 0, 0, 0, 32'hDEADBEEF, 4'b1000, 32'h100, 0);
      ec = 32'hDEADBEEF;
      add(5'b01000, 32'h100, 0, 0, 0, 32'hDEADBEEF, 4'b0010, 0, 0);
      add(5'b00011, 0, 0, 32'h40, 32'h12345678, 32'h0BADF00D, 4'b0000, 0, 0);
      add(5'b00011, 0, 0, 32'h40, 32'h12345678, 32'h0BADF00D, 4'b1100, 32'h40, 32'h12345678);
      add(5'b00011, 0, 0, 32'h40, 32'h12345678, 32'h0BADF00D, 4'b1000, 32'h40, 32'h12345678);
      cd = 1'b0;
      add(5'b00011, 0, 0, 32'h40, 32'h12345678, 32'h0BADF00D, 4'b0001, 0, 0);
      for (int k = 0; k < 4; k++) begin
`ifdef RR_PRIORITY_EN
         w = (k % 2) == 1;
`else
         w = 1'b0;
`endif
         v = 32'hA000_0000 + 32'(k);
         a = w ? 32'h300 : 32'h200;
         add(5'b01010, 32'h200, 0, 32'h300, 0, v, 4'b0000, 0, 0);
         add(5'b01010, 32'h200, 0, 32'h300, 0, v, 4'b1000, a, 0);
         add(5'b01010, 32'h200, 0, 32'h300, 0, v, 4'b1000, a, 0);
         if (w) begin ed = v; cd = 1'b1; end else begin ec = v; cc = 1'b1; end
         add(5'b01010, 32'h200, 0, 32'h300, 0, v, w ? 4'b0001 : 4'b0010, 0, 0);
      end
      add(5'b00000, 0, 0, 0, 0, 0, 4'b0000, 0, 0);
      @(posedge clk);
      foreach (tbl[i]) begin
         @(negedge clk);
         rst = tbl[i].rst;
         bus2.cpu_req = tbl[i].creq; bus2.cpu_we = tbl[i].cwe;
         bus2.cpu_addr = tbl[i].caddr; bus2.cpu_wdata = tbl[i].cwd;
         bus2.dbg_req = tbl[i].dreq; bus2.dbg_we = tbl[i].dwe;
         bus2.dbg_addr = tbl[i].daddr; bus2.dbg_wdata = tbl[i].dwd;
         bus2.mem_rdata = tbl[i].mrd;
         #1;
         chk1($sformatf("row%0d mem_en", i), bus2.mem_en, tbl[i].en);
         chk1($sformatf("row%0d mem_we", i), bus2.mem_we, tbl[i].we);
         chk1($sformatf("row%0d cpu_ready", i), bus2.cpu_ready, tbl[i].crdy);
         chk1($sformatf("row%0d dbg_ack", i), bus2.dbg_ack, tbl[i].dack);
         if (tbl[i].en) begin
            chk($sformatf("row%0d mem_addr", i), bus2.mem_addr, tbl[i].addr);
            chk($sformatf("row%0d mem_wdata", i), bus2.mem_wdata, tbl[i].wd);
         end
         if (tbl[i].chk_c) chk($sformatf("row%0d cpu_rdata", i), bus2.cpu_rdata, tbl[i].crd);
         if (tbl[i].chk_d) chk($sformatf("row%0d dbg_rdata", i), bus2.dbg_rdata, tbl[i].drd);
      end
      @(negedge clk);
      bus2.cpu_req = 1'b1; bus2.cpu_we = 1'b0; bus2.cpu_addr = 32'h500;
      bus2.dbg_req = 1'b0; bus2.mem_rdata = 32'h55555555;
      pulses = 0; at = 0; acks = 0; rd = '0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk); #1;
         if (c == 1) begin
            chk1("drop mem_en", bus2.mem_en, 1'b1);
            bus2.cpu_req = 1'b0;
         end
         if (bus2.cpu_ready) begin pulses++; at = c; rd = bus2.cpu_rdata; end
         if (bus2.dbg_ack) acks++;
      end
      chk("drop ready pulses", pulses, 1);
      chk("drop ready cycle", at, 3);
      chk("drop cpu_rdata", rd, 32'h55555555);
      chk("drop dbg_ack pulses", acks, 0);
      @(negedge clk);
      bus2.cpu_req = 1'b1; bus2.cpu_we = 1'b1; bus2.cpu_addr = 32'h600; bus2.cpu_wdata = 32'h66;
      @(negedge clk); #1;
      chk1("rstmid mem_en before", bus2.mem_en, 1'b1);
      chk1("rstmid mem_we before", bus2.mem_we, 1'b1);
      rst = 1'b1; bus2.cpu_req = 1'b0; bus2.cpu_we = 1'b0;
      @(negedge clk); #1;
      chk1("rstmid mem_en", bus2.mem_en, 1'b0);
      chk1("rstmid mem_we", bus2.mem_we, 1'b0);
      chk1("rstmid cpu_ready", bus2.cpu_ready, 1'b0);
      chk1("rstmid dbg_ack", bus2.dbg_ack, 1'b0);
      chk("rstmid cpu_rdata", bus2.cpu_rdata, 0);
      chk("rstmid dbg_rdata", bus2.dbg_rdata, 0);
      rst = 1'b0;
      pulses = 0; ens = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk); #1;
         if (bus2.cpu_ready || bus2.dbg_ack) pulses++;
         if (bus2.mem_en) ens++;
      end
      chk("rstmid late pulses", pulses, 0);
      chk("rstmid late mem_en", ens, 0);
      bus1.cpu_req = 1'b1; bus1.cpu_we = 1'b0; bus1.cpu_addr = 32'h700; bus1.mem_rdata = 32'h77777777;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk); #1;
         chk1($sformatf("lat1 rd c%0d mem_en", c), bus1.mem_en, c == 1);
         chk1($sformatf("lat1 rd c%0d cpu_ready", c), bus1.cpu_ready, c == 2);
         if (c == 1) chk("lat1 rd mem_addr", bus1.mem_addr, 32'h700);
         if (c == 2) begin
            chk("lat1 cpu_rdata", bus1.cpu_rdata, 32'h77777777);
            bus1.cpu_req = 1'b0;
         end
      end
      bus1.dbg_req = 1'b1; bus1.dbg_we = 1'b1; bus1.dbg_addr = 32'h80; bus1.dbg_wdata = 32'hCAFEF00D;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk); #1;
         chk1($sformatf("lat1 wr c%0d mem_we", c), bus1.mem_we, c == 1);
         chk1($sformatf("lat1 wr c%0d dbg_ack", c), bus1.dbg_ack, c == 2);
         if (c == 1) begin
            chk("lat1 wr mem_addr", bus1.mem_addr, 32'h80);
            chk("lat1 wr mem_wdata", bus1.mem_wdata, 32'hCAFEF00D);
         end
         if (c == 2) bus1.dbg_req = 1'b0;
      end
      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end
endmodule

// File: doc/mio_arbiter.md
# mio_arbiter

Shares the single data-memory port between the single-cycle CPU's memory interface (CPU_MIO / MemRW / Addr_out / Data_out / Data_in / MIO_ready) and a second requester, the debug/DMA port. The arbiter grants one requester at a time and sequences each access through a fixed-latency memory. It returns read data and a one-cycle ready pulse to the winner. It sits between SCPU and the data RAM inside the top-level SoC.

## Interface
- MEM_LAT, 1, memory latency in cycles from the first mem_en cycle to valid mem_rdata; legal range 1..15.

- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU access request (CPU_MIO).
- cpu_we  in  1  CPU write enable (MemRW).
- cpu_addr  in  32  CPU byte address.
- cpu_wdata  in  32  CPU write data.
- cpu_rdata  out  32  read data returned to the CPU (Data_in).
- cpu_ready  out  1  CPU completion pulse (MIO_ready).
- dbg_req  in  1  debug/DMA access request.
- dbg_we  in  1  debug write enable.
- dbg_addr  in  32  debug byte address.
- dbg_wdata  in  32  debug write data.
- dbg_rdata  out  32  read data returned to debug.
- dbg_ack  out  1  debug completion pulse.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write strobe.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data.

## Operation
- **FSM states:** IDLE, ACCESS, RESP.
- **IDLE:**
  - If any request is high, arbitrate.
  - Latch the winner's we/addr/wdata and a grant id (0 = CPU, 1 = debug).
  - Load the latency counter with MEM_LAT-1, then go to ACCESS.
- **ACCESS:**
  - mem_en = 1; mem_addr and mem_wdata come from the latched values.
  - mem_we = latched we, asserted in the first ACCESS cycle only, so exactly one write occurs.
  - Counter decrements each cycle. When the counter reaches 0, capture mem_rdata into the winner's rdata register and go to RESP.
- **RESP:**
  - Pulse the winner's ready/ack for exactly one cycle.
  - Update last_grant, then return to IDLE.
- **Data:**
  - For writes, the rdata registers still capture mem_rdata; the value is don't-care.
  - The loser's rdata register holds its previous value.
- **Request rules:**
  - A requester holds req and its fields stable until its ready/ack pulse.
  - Fields are latched in IDLE, so later changes are ignored.
  - If a request is dropped mid-transaction, the access still completes and the pulse is still issued.
- **Back-to-back:** a request still high in the IDLE cycle after RESP is treated as a new transaction. A requester therefore deasserts req in the cycle after its pulse.
- **Counter width:** 4 bits; no wrap, because it is reloaded each transaction.

## Timing
- **Reset values:** state = IDLE; all outputs 0; cpu_rdata = dbg_rdata = 0; last_grant = 1 (debug), so the CPU wins the first tie.
- **Latency:** a request sampled high in IDLE at cycle 0 produces:
  - mem_en in cycles 1..MEM_LAT;
  - ready/ack high in cycle MEM_LAT+1;
  - new rdata valid in that same cycle.
- **Throughput:** one access per MEM_LAT+2 cycles.
- **Simultaneous requests:** resolved only in IDLE, per the Configuration rule.
- **Reset mid-operation:** takes effect on the next edge. The FSM returns to IDLE with all outputs 0, and no ready/ack is issued. A write strobe already issued is not undone.
- **Single-cycle CPU:** the CPU must stall on !cpu_ready. cpu_ready is never asserted outside RESP.

## Configuration
- **RR_PRIORITY_EN defined:** round-robin.
  - On simultaneous requests, the requester not granted last (by last_grant) wins.
  - Neither requester can starve.
- **RR_PRIORITY_EN undefined:** fixed priority.
  - The CPU always wins ties.
  - last_grant is still updated but unused.
  - The debug port can starve under continuous CPU traffic.

## Test plan
- **Reset:** hold rst for 2 cycles while cpu_req = 1 → all outputs 0, no mem_en. After release, the access starts in the first IDLE cycle.
- **CPU read, MEM_LAT = 2, mem returns 0xDEADBEEF:**
  - cpu_req at cycle 0 with addr 0x100 → mem_en/mem_addr = 0x100 in cycles 1–2.
  - cpu_ready pulse and cpu_rdata = 0xDEADBEEF in cycle 3.
  - dbg_ack stays 0.
- **Debug write, addr 0x40, data 0x12345678:** mem_we high in exactly one cycle with mem_wdata = 0x12345678, followed by a single dbg_ack pulse.
- **Simultaneous requests held continuously, RR_PRIORITY_EN defined:** grants alternate CPU, debug, CPU, debug. Without the macro, 4 consecutive CPU grants and no dbg_ack.
- **Mid-transaction events:**
  - Drop cpu_req during ACCESS → cpu_ready still pulses once.
  - Assert rst during ACCESS → next cycle state is IDLE, mem_en = 0, and no pulse is issued.
- **MEM_LAT = 1:** req at cycle 0 → mem_en only in cycle 1, ready in cycle 2.
